// File: rtl/v_inst_queue.sv
`default_nettype none
// ============================================================================
// v_inst_queue: vector instruction issue queue, one registered issue or NOP/cycle
// Rev 1.0
// ============================================================================
module v_inst_queue #(
  parameter int                DEPTH    = 4,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [INST_W-1:0]          enq_inst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic [INST_W-1:0]          inst_o,
  output logic                       inst_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              accept, pop;

  // Wrap bit distinguishes full from empty when the low pointer bits match.
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign enq_ready_o = !full_o && !flush_i && !rst;
  assign accept      = enq_valid_i && enq_ready_o;
  assign pop         = !empty_o && !stall_i && !flush_i;

  assign inst_o       = inst_q;
  assign inst_valid_o = inst_valid_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    inst_d       = NOP_INST;
    inst_valid_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + 1'b1;
        inst_d       = mem_q[rd_ptr_q[AW-1:0]];
        inst_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Storage is deliberately unreset; the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= enq_inst_i;
  end

endmodule
`default_nettype wire
